// File: rtl/spi_slave_if.sv
`timescale 1ns/1ps
// spi_slave_if: SPI command-frame deserialiser with a serial read-data return path.
// Define SPI_FRAME_ERR_EN to add the frame_err early-release pulse output.
module spi_slave_if #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic               frame_err
`endif
);
  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam int TX_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] BIT_DONE = CNT_W'(FRAME_W);
  localparam logic [TX_W-1:0]  TX_LAST  = TX_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-2:0] shift_reg;
  logic               rd_addr_done;
  logic [DATA_W-2:0]  tx_sh;
  logic [TX_W-1:0]    tx_left;
  logic               tx_busy, tx_fin;
  logic               abort, frame_done, sample_bit, last_bit, tx_load, tx_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!ss_n) state_nxt = CHK_CMD;
      CHK_CMD: begin
        if (ss_n)              state_nxt = IDLE;
        else if (!mosi)        state_nxt = WRITE;
        else if (rd_addr_done) state_nxt = READ_DATA;
        else                   state_nxt = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: if (ss_n) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Once all frame bits are in, bit_cnt parks at BIT_DONE and extra mosi bits are dropped.
  always_comb begin
    abort      = (state != IDLE) && ss_n;
    frame_done = (bit_cnt == BIT_DONE);
    sample_bit = (state != IDLE) && !ss_n && !frame_done;
    last_bit   = sample_bit && (bit_cnt == BIT_LAST);
    tx_load    = (state == READ_DATA) && !ss_n && frame_done && !tx_busy && !tx_fin && tx_valid;
    tx_shift   = (state == READ_DATA) && !ss_n && tx_busy;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt      <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_done <= 1'b0;
    end else begin
      rx_valid <= last_bit;
      if (state == IDLE || abort) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else if (sample_bit) begin
        bit_cnt   <= bit_cnt + CNT_W'(1);
        shift_reg <= {shift_reg[FRAME_W-3:0], mosi};
      end
      if (last_bit) begin
        rx_data <= {shift_reg, mosi};
        if (state == READ_ADD)       rd_addr_done <= 1'b1;
        else if (state == READ_DATA) rd_addr_done <= 1'b0;
      end
    end
  end

  // First response bit goes out on the load edge; tx_left counts the bits still queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miso    <= 1'b0;
      tx_sh   <= '0;
      tx_left <= '0;
      tx_busy <= 1'b0;
      tx_fin  <= 1'b0;
    end else if (state == IDLE || abort) begin
      miso    <= 1'b0;
      tx_sh   <= '0;
      tx_left <= '0;
      tx_busy <= 1'b0;
      tx_fin  <= 1'b0;
    end else if (tx_load) begin
      miso    <= tx_data[DATA_W-1];
      tx_sh   <= tx_data[DATA_W-2:0];
      tx_left <= TX_LAST;
      tx_busy <= 1'b1;
    end else if (tx_shift) begin
      if (tx_left != '0) begin
        miso    <= tx_sh[DATA_W-2];
        tx_sh   <= {tx_sh[DATA_W-3:0], 1'b0};
        tx_left <= tx_left - TX_W'(1);
      end else begin
        miso    <= 1'b0;
        tx_busy <= 1'b0;
        tx_fin  <= 1'b1;
      end
    end
  end

`ifdef SPI_FRAME_ERR_EN
  logic tx_all_out;
  assign tx_all_out = tx_fin || (tx_busy && (tx_left == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_err <= 1'b0;
    else       frame_err <= abort && (!frame_done || ((state == READ_DATA) && !tx_all_out));
  end
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
`timescale 1ns/1ps
// Bench for spi_slave_if: directed test-plan steps followed by randomized frames
// checked against a transaction-level model of the command/read protocol.
module tb_spi_slave_if;
  logic       clk = 1'b0;
  logic       reset, ss_n, mosi, tx_valid;
  logic [7:0] tx_data;
  logic       miso, rx_valid;
  logic [9:0] rx_data;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  int passed = 0;
  int total  = 0;
  int vcount = 0;
  logic m_or = 1'b0;

  // Transaction-level model: read-address-seen flag and last delivered frame.
  bit         model_rd = 1'b0;
  logic [9:0] model_rx = '0;

  spi_slave_if #(.FRAME_W(10), .DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rx_valid === 1'b1) vcount++;
    if (miso !== 1'b0) m_or = 1'b1;
  endtask

  // Sends the first nbits bits of f (10 = complete frame, fewer = abort).
  task automatic send_frame(input logic [9:0] f, input int nbits, output bit is_rd);
    bit was_rd;
    is_rd  = 1'b0;
    vcount = 0;
    m_or   = 1'b0;
    ss_n   = 1'b0;
    mosi   = 1'($urandom_range(0, 1));
    tick();
    for (int b = 0; b < nbits; b++) begin
      mosi     = f[9-b];
      tx_valid = 1'($urandom_range(0, 1));
      tick();
    end
    tx_valid = 1'b0;
    if (nbits == 10) begin
      check("rx_valid_pulse", {31'd0, rx_valid}, 32'd1);
      check("rx_valid_count", vcount, 1);
      check("rx_data", {22'd0, rx_data}, {22'd0, f});
      check("miso_during_frame", {31'd0, m_or}, 32'd0);
      was_rd   = model_rd;
      is_rd    = f[9] && was_rd;
      if (f[9]) model_rd = !was_rd;
      model_rx = f;
      mosi     = 1'($urandom_range(0, 1));
      tick();
      check("rx_valid_one_cycle", {31'd0, rx_valid}, 32'd0);
    end else begin
      ss_n = 1'b1;
      tick();
      check("abort_no_valid", vcount, 0);
      check("abort_rx_hold", {22'd0, rx_data}, {22'd0, model_rx});
      check("abort_miso", {31'd0, m_or}, 32'd0);
`ifdef SPI_FRAME_ERR_EN
      check("frame_err_abort", {31'd0, frame_err}, 32'd1);
`endif
      tick();
`ifdef SPI_FRAME_ERR_EN
      check("frame_err_one_cycle", {31'd0, frame_err}, 32'd0);
`endif
    end
  endtask

  // Offers a response after delay cycles, observes nb miso bits, then releases ss_n.
  task automatic respond(input bit active, input logic [7:0] d, input int delay, input int nb);
    logic [7:0] word;
    logic [7:0] exp;
    word   = '0;
    vcount = 0;
    m_or   = 1'b0;
    for (int i = 0; i < delay; i++) begin
      mosi = 1'($urandom_range(0, 1));
      tick();
    end
    check("miso_wait", {31'd0, m_or}, 32'd0);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    for (int i = 0; i < nb; i++) begin
      if (i > 0) begin
        mosi = 1'($urandom_range(0, 1));
        tick();
      end
      word = {word[6:0], miso};
    end
    exp = active ? (d >> (8 - nb)) : 8'h00;
    check("miso_word", {24'd0, word}, {24'd0, exp});
    if (nb == 8) begin
      tick();
      check("miso_tail", {31'd0, miso}, 32'd0);
    end
    ss_n = 1'b1;
    tick();
    check("miso_after_release", {31'd0, miso}, 32'd0);
`ifdef SPI_FRAME_ERR_EN
    check("frame_err_read", {31'd0, frame_err}, {31'd0, (active && nb < 8)});
`endif
    check("no_extra_valid", vcount, 0);
    check("rx_hold", {22'd0, rx_data}, {22'd0, model_rx});
  endtask

  initial begin
    bit rd;
    logic [9:0] f;
    int nb;
    reset    = 1'b0;
    ss_n     = 1'b1;
    mosi     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    #2 reset = 1'b1;
    #1;
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {22'd0, rx_data}, 32'd0);
`ifdef SPI_FRAME_ERR_EN
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
`endif
    tick();
    tick();
    #3 reset = 1'b0;

    // Stray handshake while idle.
    m_or = 1'b0;
    vcount = 0;
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    for (int i = 0; i < 3; i++) tick();
    tx_valid = 1'b0;
    check("idle_stray_miso", {31'd0, m_or}, 32'd0);
    check("idle_no_valid", vcount, 0);

    // Write address, write data (with stray handshakes in WRITE).
    send_frame(10'h007, 10, rd);
    respond(rd, 8'hC3, 1, 8);
    send_frame(10'h103, 10, rd);
    respond(rd, 8'h5A, 0, 8);

    // Read address then read data.
    send_frame(10'h207, 10, rd);
    respond(rd, 8'hFF, 0, 8);
    send_frame(10'h300, 10, rd);
    respond(rd, 8'h03, 1, 8);

    // Abort write-data after 5 bits.
    send_frame(10'h103, 5, rd);

    // Abort a read-data frame, then abort its response mid-shift.
    send_frame(10'h2FF, 10, rd);
    respond(rd, 8'h81, 2, 8);
    send_frame(10'h3AA, 6, rd);
    send_frame(10'h355, 10, rd);
    respond(rd, 8'hB7, 2, 3);

    // Reset during the third miso bit of 0xA5.
    if (!model_rd) begin
      send_frame(10'h211, 10, rd);
      respond(rd, 8'h00, 0, 8);
    end
    send_frame(10'h3C0, 10, rd);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("rst_bit7", {31'd0, miso}, 32'd1);
    tick();
    check("rst_bit6", {31'd0, miso}, 32'd0);
    tick();
    check("rst_bit5", {31'd0, miso}, 32'd1);
    #2;
    reset = 1'b1;
    ss_n  = 1'b1;
    #1;
    check("rst_async_miso", {31'd0, miso}, 32'd0);
    check("rst_async_rx_data", {22'd0, rx_data}, 32'd0);
    check("rst_async_rx_valid", {31'd0, rx_valid}, 32'd0);
    model_rd = 1'b0;
    model_rx = '0;
    #3 reset = 1'b0;
    tick();
    send_frame(10'h2C3, 10, rd);
    respond(rd, 8'hE7, 1, 8);
    send_frame(10'h3F0, 10, rd);
    respond(rd, 8'h69, 0, 8);

    // Randomized frames, aborts and responses.
    for (int it = 0; it < 30; it++) begin
      f  = 10'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 10;
      send_frame(f, nb, rd);
      if (nb == 10)
        respond(rd, 8'($urandom), int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
